// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator
//   Downstream stage of the 64x64 multiplier. It sums a burst of unsigned
//   128-bit products into a wide accumulator. When the beat tagged "last" is
//   accepted, it presents the total, the term count and a sticky overflow
//   flag on a valid/ready result port.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
//   valid & ready are both 1. A source holds valid and its payload stable
//   until that edge. ready never depends on valid.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_prod_valid  in   product beat valid
//   o_prod_ready  out  block can accept a beat (registered, state only)
//   i_prod        in   [PROD_W] unsigned product
//   i_prod_last   in   beat is the final term of the burst
//   i_acc_clear   in   discard the partial burst (ignored while holding)
//   o_res_valid   out  result held and valid
//   i_res_ready   in   downstream accepts the result
//   o_res_sum     out  [ACC_W] accumulated sum
//   o_res_cnt     out  [CNT_W] number of terms (saturating)
//   o_res_ovf     out  sum overflowed ACC_W during the burst
//   o_dbg_state   out  current FSM state (0 = ACCUM, 1 = HOLD)
//
// Build option
//   MULT_ACC_SAT_EN defined: an add with carry-out loads all-ones into the
//   accumulator instead of the wrapped value. Undefined: modular wrap.
//   res_ovf flags the event in both builds.

module mult_product_accumulator #(
  parameter int PROD_W = 128,
  parameter int ACC_W  = 136,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_prod_last,
  input  logic              i_acc_clear,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ACC_W-1:0]  o_res_sum,
  output logic [CNT_W-1:0]  o_res_cnt,
  output logic              o_res_ovf,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  typedef logic [ACC_W:0] sum_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic               r_prod_ready;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_res_valid;
  logic [ACC_W-1:0]   r_res_sum;
  logic [CNT_W-1:0]   r_res_cnt;
  logic               r_res_ovf;

  logic               w_accept;
  logic [ACC_W-1:0]   w_acc_base;
  logic [CNT_W-1:0]   w_cnt_base;
  logic               w_ovf_base;
  sum_t               w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_ovf_next;

  // r_prod_ready is only ever 1 in ACCUM, so an accept implies ACCUM.
  assign w_accept = i_prod_valid & r_prod_ready;

  // A clear in the same cycle as a beat discards the old partial sum, so
  // the beat starts a fresh burst: clear selects zero as the add base.
  assign w_acc_base = i_acc_clear ? '0 : r_acc;
  assign w_cnt_base = i_acc_clear ? '0 : r_cnt;
  assign w_ovf_base = i_acc_clear ? 1'b0 : r_ovf;

  // One extra bit on the adder captures the carry-out of the ACC_W add.
  assign w_sum   = sum_t'(w_acc_base) + sum_t'(i_prod);
  assign w_carry = w_sum[ACC_W];

`ifdef MULT_ACC_SAT_EN
  // Once saturated, any further add (even +0) keeps all-ones: all-ones plus
  // a nonzero product carries again, and plus zero is unchanged.
  assign w_acc_next = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign w_cnt_next = (w_cnt_base == CNT_MAX) ? CNT_MAX : w_cnt_base + 1'b1;
  assign w_ovf_next = w_ovf_base | w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCUM;
      r_prod_ready <= 1'b1;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_sum    <= '0;
      r_res_cnt    <= '0;
      r_res_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (i_prod_last) begin
              r_res_sum    <= w_acc_next;
              r_res_cnt    <= w_cnt_next;
              r_res_ovf    <= w_ovf_next;
              r_res_valid  <= 1'b1;
              r_prod_ready <= 1'b0;
              r_state      <= ST_HOLD;
            end
          end else if (i_acc_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        ST_HOLD: begin
          // acc_clear is ignored here; the pending result is never dropped.
          if (r_res_valid && i_res_ready) begin
            r_res_valid  <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b1;
            r_state      <= ST_ACCUM;
          end
        end
        default: begin
          r_state      <= ST_ACCUM;
          r_prod_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_prod_ready = r_prod_ready;
  assign o_res_valid  = r_res_valid;
  assign o_res_sum    = r_res_sum;
  assign o_res_cnt    = r_res_cnt;
  assign o_res_ovf    = r_res_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mult_product_accumulator.sv
module tb_mult_product_accumulator;

  localparam int PROD_W = 128;
  localparam int ACC_W  = 136;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_prod_valid = 1'b0;
  logic              o_prod_ready;
  logic [PROD_W-1:0] i_prod = '0;
  logic              i_prod_last = 1'b0;
  logic              i_acc_clear = 1'b0;
  logic              o_res_valid;
  logic              i_res_ready = 1'b1;
  logic [ACC_W-1:0]  o_res_sum;
  logic [CNT_W-1:0]  o_res_cnt;
  logic              o_res_ovf;
  logic              o_dbg_state;

  mult_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_prod_valid(i_prod_valid), .o_prod_ready(o_prod_ready),
    .i_prod(i_prod), .i_prod_last(i_prod_last), .i_acc_clear(i_acc_clear),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_sum(o_res_sum), .o_res_cnt(o_res_cnt), .o_res_ovf(o_res_ovf),
    .o_dbg_state(o_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // The burst total is kept as a plain wide integer; the result is derived
  // from it: wrap = total mod 2^ACC_W, saturate = all-ones if total overflowed.
  logic [159:0] m_total = '0;
  int           m_terms = 0;
  logic [144:0] exp_q[$];   // {ovf, cnt, sum}

  function automatic logic [144:0] model_result(logic [159:0] total, int terms);
    logic [159:0] lim;
    logic         ovf;
    logic [135:0] sum;
    logic [7:0]   cnt;
    lim = 160'd1 << ACC_W;
    ovf = (total >= lim);
`ifdef MULT_ACC_SAT_EN
    sum = ovf ? {ACC_W{1'b1}} : total[135:0];
`else
    sum = total[135:0];
`endif
    cnt = (terms > 255) ? 8'd255 : 8'(terms);
    return {ovf, cnt, sum};
  endfunction

  function automatic void model_accept(logic [127:0] p, logic l, logic c);
    if (c) begin
      m_total = '0;
      m_terms = 0;
    end
    m_total = m_total + 160'(p);
    m_terms++;
    if (l) begin
      exp_q.push_back(model_result(m_total, m_terms));
      m_total = '0;
      m_terms = 0;
    end
  endfunction

  function automatic void model_reset();
    m_total = '0;
    m_terms = 0;
    exp_q.delete();
  endfunction

  // ---------------- scoreboard ----------------
  // A result transfers on the next rising edge whenever valid & ready are
  // seen here; each transfer is matched against the model in order.
  always @(negedge clk) begin
    if (rst_n && o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 160'(o_res_valid), 160'd0);
      end else begin
        logic [144:0] e;
        e = exp_q.pop_front();
        check("sb_sum", 160'(o_res_sum), 160'(e[135:0]));
        check("sb_cnt", 160'(o_res_cnt), 160'(e[143:136]));
        check("sb_ovf", 160'(o_res_ovf), 160'(e[144]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic beat(input logic [127:0] p, input logic l, input logic c);
    logic rdy;
    bit   ok;
    i_prod_valid = 1'b1;
    i_prod       = p;
    i_prod_last  = l;
    i_acc_clear  = c;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      rdy = o_prod_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    if (!ok) check("beat_accept_timeout", 160'd0, 160'd1);
    else model_accept(p, l, c);
    i_prod_valid = 1'b0;
    i_prod_last  = 1'b0;
    i_acc_clear  = 1'b0;
  endtask

  task automatic clear_only();
    i_acc_clear = 1'b1;
    @(posedge clk);
    #1;
    m_total = '0;
    m_terms = 0;
    i_acc_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         valid;    // 0: clear-only cycle
    logic [127:0] prod;
    logic         last;
    logic         clear;
    logic         chk;      // compare result outputs after this step
    logic [135:0] exp_sum;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [127:0] all_ones;
    logic [135:0] exp_big;
    all_ones = '1;

    vecs[0] = '{1'b1, 128'd4, 1'b0, 1'b0, 1'b0, 136'd0, 8'd0};
    vecs[1] = '{1'b1, 128'd6, 1'b0, 1'b0, 1'b0, 136'd0, 8'd0};
    vecs[2] = '{1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 136'd0, 8'd0};
    vecs[3] = '{1'b1, 128'd9, 1'b1, 1'b0, 1'b1, 136'd9, 8'd1};
    vecs[4] = '{1'b1, 128'd2, 1'b0, 1'b1, 1'b0, 136'd0, 8'd0};
    vecs[5] = '{1'b1, 128'd3, 1'b1, 1'b0, 1'b1, 136'd5, 8'd2};
    vecs[6] = '{1'b1, 128'd0, 1'b1, 1'b0, 1'b1, 136'd0, 8'd1};
    vecs[7] = '{1'b1, 128'd1, 1'b0, 1'b0, 1'b0, 136'd0, 8'd0};
    vecs[8] = '{1'b1, all_ones, 1'b1, 1'b0, 1'b1, 136'd1 << 128, 8'd2};
    vecs[9] = '{1'b1, 128'd7, 1'b1, 1'b1, 1'b1, 136'd7, 8'd1};

    // ---- reset state ----
    #12 rst_n = 1'b1;
    #1;
    idle(1);
    check("rst_prod_ready", 160'(o_prod_ready), 160'd1);
    check("rst_res_valid",  160'(o_res_valid),  160'd0);
    check("rst_res_sum",    160'(o_res_sum),    160'd0);
    check("rst_res_cnt",    160'(o_res_cnt),    160'd0);
    check("rst_res_ovf",    160'(o_res_ovf),    160'd0);

    // ---- table-driven vectors ----
    i_res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].valid) beat(vecs[i].prod, vecs[i].last, vecs[i].clear);
      else clear_only();
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_valid", i), 160'(o_res_valid), 160'd1);
        check($sformatf("vec%0d_sum", i),   160'(o_res_sum),   160'(vecs[i].exp_sum));
        check($sformatf("vec%0d_cnt", i),   160'(o_res_cnt),   160'(vecs[i].exp_cnt));
        check($sformatf("vec%0d_ovf", i),   160'(o_res_ovf),   160'd0);
      end
    end
    // Leave a burst whose result is nonzero and held after handoff.
    beat(128'd1, 1'b0, 1'b0);
    beat(all_ones, 1'b1, 1'b0);
    idle(2);

    // ---- reset mid-burst ----
    beat(128'd7, 1'b0, 1'b0);
    beat(128'd8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 160'(o_res_valid), 160'd0);
    check("midrst_res_sum",   160'(o_res_sum),   160'd0);
    check("midrst_res_cnt",   160'(o_res_cnt),   160'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("postrst_prod_ready", 160'(o_prod_ready), 160'd1);
    beat(128'd5, 1'b1, 1'b0);
    check("postrst_sum", 160'(o_res_sum), 160'd5);
    check("postrst_cnt", 160'(o_res_cnt), 160'd1);
    idle(1);

    // ---- multi-beat burst, ready gap of one cycle ----
    beat(128'd3, 1'b0, 1'b0);
    beat(128'd7, 1'b0, 1'b0);
    beat(128'h1_0000_0000_0000_0000, 1'b1, 1'b0);
    check("mb_valid", 160'(o_res_valid), 160'd1);
    check("mb_ready_low", 160'(o_prod_ready), 160'd0);
    check("mb_sum", 160'(o_res_sum), 160'h1_0000_0000_0000_000A);
    check("mb_cnt", 160'(o_res_cnt), 160'd3);
    check("mb_ovf", 160'(o_res_ovf), 160'd0);
    idle(1);
    check("mb_ready_back", 160'(o_prod_ready), 160'd1);
    check("mb_valid_drop", 160'(o_res_valid), 160'd0);
    check("mb_sum_kept", 160'(o_res_sum), 160'h1_0000_0000_0000_000A);

    // ---- backpressure, clear in HOLD ignored ----
    i_res_ready = 1'b0;
    beat(128'd11, 1'b1, 1'b0);
    i_prod_valid = 1'b1;
    i_prod       = 128'd100;
    i_prod_last  = 1'b1;
    i_acc_clear  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check($sformatf("bp_ready%0d", k), 160'(o_prod_ready), 160'd0);
      check($sformatf("bp_valid%0d", k), 160'(o_res_valid), 160'd1);
      check($sformatf("bp_sum%0d", k), 160'(o_res_sum), 160'd11);
    end
    i_acc_clear = 1'b0;
    i_res_ready = 1'b1;
    beat(128'd100, 1'b1, 1'b0);
    check("bp_new_sum", 160'(o_res_sum), 160'd100);
    check("bp_new_cnt", 160'(o_res_cnt), 160'd1);
    idle(1);

    // ---- randomized bursts against the model ----
    for (int b = 0; b < 30; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        logic [127:0] p;
        logic         c;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) p = 128'($urandom_range(0, 15));
        c = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) clear_only();
        beat(p, (j == len - 1), c);
      end
      i_res_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      i_res_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    // ---- overflow: 257 full-scale beats ----
    for (int j = 0; j < 257; j++) beat(all_ones, (j == 256), 1'b0);
`ifdef MULT_ACC_SAT_EN
    exp_big = '1;
`else
    exp_big = (136'd1 << 128) - 136'd257;
`endif
    check("ovf_sum", 160'(o_res_sum), 160'(exp_big));
    check("ovf_cnt", 160'(o_res_cnt), 160'd255);
    check("ovf_flag", 160'(o_res_ovf), 160'd1);
    idle(3);

    check("sb_queue_empty", 160'(exp_q.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream stage of the 64x64 combinational multiplier: registers each 128-bit product and sums a burst of products into a wide accumulator.
- Upstream logic launches a burst of operand pairs and tags the final pair with a last flag.
- When the last product arrives, the block presents the total with an overflow flag and a term count on a valid/ready result port.
- The burst sum is then consumed by the dot-product / result-writeback logic.

Parameters:
- PROD_W, 128, product width; matches multiplier output.
- ACC_W, 136, accumulator width; must be at least PROD_W (8 guard bits).
- CNT_W, 8, term counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prod_valid  input  1  product beat valid.
- prod_ready  output  1  block can accept a product beat.
- prod  input  PROD_W  unsigned product from the multiplier.
- prod_last  input  1  beat is the final term of the burst.
- acc_clear  input  1  discard the partial burst.
- res_valid  output  1  result held and valid.
- res_ready  input  1  downstream accepts the result.
- res_sum  output  ACC_W  accumulated sum.
- res_cnt  output  CNT_W  number of terms in the burst.
- res_ovf  output  1  sum overflowed ACC_W during the burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM; accumulator, term counter and sticky overflow = 0.
  - res_valid=0, res_sum=0, res_cnt=0, res_ovf=0; prod_ready=1 once reset is released.
- Two states, ACCUM and HOLD.
  - ACCUM: prod_ready=1.
  - HOLD: prod_ready=0; the result registers are stable.
  - prod_ready is a registered function of state only and must not depend on prod_valid.
- Accept rule: a beat is taken when prod_valid & prod_ready.
- On an accepted beat in ACCUM:
  - acc <= acc + zero_extend(prod), modulo 2^ACC_W.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - ovf <= ovf | carry-out of the ACC_W add.
- Accepted beat with prod_last=1:
  - res_sum <= acc+prod, res_cnt <= cnt+1 (saturating), res_ovf <= ovf|carry.
  - res_valid <= 1; state <= HOLD.
  - Latency: res_valid rises on the edge that accepts the last beat, i.e. visible the following cycle.
- Single-beat burst (first beat has prod_last=1): res_cnt=1, res_sum=prod.
- HOLD:
  - On res_valid & res_ready: res_valid <= 0; acc, cnt and ovf <= 0; state <= ACCUM.
  - prod_ready returns to 1 in the next cycle, so the minimum gap between bursts is 1 idle cycle.
  - res_sum, res_cnt and res_ovf keep their values after handoff until the next result is loaded.
- acc_clear in ACCUM, no beat accepted: acc, cnt and ovf <= 0.
- acc_clear in ACCUM, beat accepted the same cycle: clear has priority over the old partial sum.
  - acc <= prod, cnt <= 1, ovf <= 0.
  - If prod_last=1, the result is prod with cnt 1.
- acc_clear in HOLD: ignored; the pending result is never dropped.
- prod_valid while in HOLD: not accepted (prod_ready=0). The upstream source must hold the beat.
- Reset mid-burst or during HOLD: the partial sum and any pending result are lost and all outputs return to their reset values immediately (asynchronous).
- Arithmetic is unsigned only. With default widths, overflow needs more than 256 full-scale products.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined: an add whose carry-out is set loads all-ones into acc instead of the wrapped value. res_ovf still flags the event. Subsequent adds stay at all-ones.
- Undefined: modular wrap as described above, with res_ovf set.
- Port list is identical in both builds.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-burst after 2 beats -> res_valid=0, res_sum=0, res_cnt=0 immediately.
  - After release, prod_ready=1; a new burst of 1 beat prod=5, last=1 -> res_sum=5, res_cnt=1.
- Multi-beat burst: prod=3, 7, 0x1_0000_0000_0000_0000 (last on the third), back-to-back, res_ready=1 -> res_valid one cycle after the third beat; res_sum=0x1_0000_0000_0000_000A, res_cnt=3, res_ovf=0; prod_ready low for exactly 1 cycle.
- Backpressure: res_ready=0 for 5 cycles after the result, prod_valid held high with a new burst -> no beat accepted, result unchanged; res_ready=1 -> handoff, then the new burst starts from acc=0.
- Clear:
  - acc_clear alone after beats 4 and 6 -> next burst 9 (last) gives res_sum=9, res_cnt=1.
  - acc_clear with a simultaneous beat 2 (not last), then beat 3 (last) -> res_sum=5, res_cnt=2.
  - acc_clear during HOLD -> result unaffected.
- Overflow, wrap build: accumulate 257 beats of all-ones (2^128-1) -> res_ovf=1, res_cnt=255 (saturated), res_sum = 257·(2^128-1) mod 2^136.
- Overflow, MULT_ACC_SAT_EN build: same stimulus -> res_sum = 2^136-1, res_ovf=1.
